// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Two-requester round-robin front end for a registered ALU. It accepts one
// request at a time over valid/ready, drives the ALU with a one-cycle enable,
// and captures the result when the ALU raises its output-valid flag. The
// result goes out, tagged with the requester ID, over a backpressured
// response port. Divide-by-zero and ALU non-response are trapped here and
// reported as errors.
//
// Parameters
//   WIDTH      operand width (must match the ALU)
//   OUT_WIDTH  result width (must match the ALU)
//   TIMEOUT    maximum WAIT cycles before an error response (>= 1)
//
// Ports
//   REF_CLK, RST                       clock (rising edge), async active-low reset
//   reqN_valid/reqN_ready              request handshake; ready is combinational
//   reqN_a, reqN_b, reqN_fun           request operands and function code
//   alu_a, alu_b, alu_fun, alu_en      registered drive to the ALU
//   alu_out, alu_out_valid             ALU result and its valid flag
//   rsp_valid/rsp_ready                response handshake
//   rsp_id, rsp_data, rsp_err          response payload
// ---------------------------------------------------------------------------
module alu_arbiter #(
   parameter int WIDTH     = 8,
   parameter int OUT_WIDTH = 16,
   parameter int TIMEOUT   = 4
) (
   input  logic                 REF_CLK,
   input  logic                 RST,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic [3:0]           req0_fun,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   input  logic [3:0]           req1_fun,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [3:0]           alu_fun,
   output logic                 alu_en,
   input  logic [OUT_WIDTH-1:0] alu_out,
   input  logic                 alu_out_valid,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [OUT_WIDTH-1:0] rsp_data,
   output logic                 rsp_err
);

   localparam int                CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [3:0]        FUN_DIV = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t                 state_q;
   logic                   last_q;      // requester granted most recently
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic [WIDTH-1:0]       alu_a_q;
   logic [WIDTH-1:0]       alu_b_q;
   logic [3:0]             alu_fun_q;
   logic                   alu_en_q;
   logic                   rsp_valid_q;
   logic                   rsp_id_q;
   logic [OUT_WIDTH-1:0]   rsp_data_q;
   logic                   rsp_err_q;

   logic                   gnt0;
   logic                   gnt1;
   logic [WIDTH-1:0]       acc_a;
   logic [WIDTH-1:0]       acc_b;
   logic [3:0]             acc_fun;

   // Divide-by-zero is trapped before the ALU ever sees it.
   function automatic logic is_div_zero(input logic [3:0] fun, input logic [WIDTH-1:0] b);
      return (fun == FUN_DIV) && (b == {WIDTH{1'b0}});
   endfunction

   // Round-robin grant in IDLE: a tie goes to the requester not granted last.
   // Both grants are held low while reset is asserted.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (RST && (state_q == ST_IDLE)) begin
         if (req0_valid && (!req1_valid || last_q)) begin
            gnt0 = 1'b1;
         end else if (req1_valid) begin
            gnt1 = 1'b1;
         end else begin
            gnt0 = 1'b0;
         end
      end else begin
         gnt0 = 1'b0;
      end
   end

   // Select the payload of whichever requester is being granted.
   always_comb begin
      acc_a   = req0_a;
      acc_b   = req0_b;
      acc_fun = req0_fun;
      if (gnt1) begin
         acc_a   = req1_a;
         acc_b   = req1_b;
         acc_fun = req1_fun;
      end else begin
         acc_a   = req0_a;
      end
   end

   assign cnt_d = cnt_q + CNT_ONE;

   // Operation sequencer with all outputs registered.
   always_ff @(posedge REF_CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         cnt_q       <= {CNT_W{1'b0}};
         alu_a_q     <= {WIDTH{1'b0}};
         alu_b_q     <= {WIDTH{1'b0}};
         alu_fun_q   <= 4'b0000;
         alu_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= {OUT_WIDTH{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt0 || gnt1) begin
                  alu_a_q   <= acc_a;
                  alu_b_q   <= acc_b;
                  alu_fun_q <= acc_fun;
                  rsp_id_q  <= gnt1;
                  last_q    <= gnt1;
                  if (is_div_zero(acc_fun, acc_b)) begin
                     rsp_data_q  <= {OUT_WIDTH{1'b0}};
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_RESP;
                  end else begin
                     // Enable is raised on entry so it is high for all of ISSUE.
                     alu_en_q <= 1'b1;
                     state_q  <= ST_ISSUE;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               alu_en_q <= 1'b0;
               cnt_q    <= {CNT_W{1'b0}};
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (alu_out_valid) begin
                  rsp_data_q  <= alu_out;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (cnt_d == CNT_MAX) begin
                  // Count reaches TIMEOUT on this edge: give up on the ALU.
                  rsp_data_q  <= {OUT_WIDTH{1'b0}};
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  cnt_q       <= cnt_d;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               alu_en_q    <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_fun    = alu_fun_q;
   assign alu_en     = alu_en_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin front end for the registered parametrized ALU. Accepts operation requests over valid/ready handshakes, grants one at a time, and drives the ALU's operand, function and enable inputs for exactly one cycle per operation. It captures the ALU result on its output-valid flag and returns the result tagged with the requester ID over a backpressured response port. Divide-by-zero and ALU non-response are trapped locally and reported as errors.

## Interface
- WIDTH, 8, operand width; must match the ALU WIDTH
- OUT_WIDTH, 16, result width; must match the ALU OUT_WIDTH
- TIMEOUT, 4, maximum WAIT cycles before an error response; must be ≥1
- REF_CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_fun / req1_fun  in  4  ALU function code
- alu_a, alu_b  out  WIDTH  operands to ALU
- alu_fun  out  4  function to ALU
- alu_en  out  1  ALU Enable
- alu_out  in  OUT_WIDTH  ALU result
- alu_out_valid  in  1  ALU OUT_VALID
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  OUT_WIDTH  result
- rsp_err  out  1  1 = divide-by-zero or timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any reqN_valid is high, grant one requester. If both are high, grant the one not granted last.
  - The last-grant register resets to 1, so req0 wins the first tie.
  - The granted reqN_ready is high in the same cycle. Operands, fun and ID latch at that edge, and last-grant updates.
  - If fun=4'b0011 and b=0, go to RESP with rsp_data=0 and rsp_err=1. The ALU is not enabled.
  - Otherwise go to ISSUE.
- ISSUE:
  - alu_en=1 for exactly one cycle; alu_a/alu_b/alu_fun show the latched values.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - alu_en=0.
  - If alu_out_valid=1, capture alu_out into rsp_data, set rsp_err=0, and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set rsp_data=0 and rsp_err=1, and go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge, go to IDLE.
- Ready outputs:
  - reqN_ready is 0 in all states except IDLE.
  - At most one ready is high per cycle.
  - Both are forced 0 while RST is low.
- alu_a, alu_b and alu_fun hold their latched values between operations. They change only on acceptance.
- Function codes 4'b1111 and above are not checked. The ALU result (0) is returned with rsp_err=0.
- rsp_data is OUT_WIDTH wide. Truncation follows the ALU's own width rules; no extension is done here.

## Timing
- Reset values:
  - req0_ready=0, req1_ready=0
  - alu_en=0, alu_a=0, alu_b=0, alu_fun=0
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0
  - Timeout counter=0, last-grant=1
- Normal operation, accepted at edge of cycle T (IDLE):
  - T+1: ISSUE, alu_en=1.
  - T+2: WAIT, alu_out_valid=1 from the ALU register.
  - T+3: RESP, rsp_valid=1.
  - Minimum period is 4 cycles per operation with rsp_ready tied high.
- Divide-by-zero: rsp_valid=1 at T+1.
- Timeout: rsp_valid=1 at T+2+TIMEOUT.
- A requester that drops valid before ready is not granted. No request is lost once ready is seen.
- Requests arriving while busy wait. The arbiter samples them in IDLE only.
- alu_out_valid outside WAIT is ignored.
- Reset mid-operation (any state):
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight request and any pending response are discarded.

## Test plan
- Single request: req0, a=8'h0F, b=8'h01, fun=0000 -> rsp_valid 3 cycles after accept; rsp_data=16'h0010, rsp_id=0, rsp_err=0; alu_en high exactly one cycle.
- Simultaneous requests: both valid for 3 operations (req0 fun=0010 a=8'hFF b=8'hFF; req1 fun=0001 a=5 b=3) -> grant order req0, req1, req0; data 16'hFE01, 16'h0002, 16'hFE01.
- Divide-by-zero: req1, fun=0011, a=9, b=0 -> alu_en never asserted; rsp at T+1 with rsp_data=0, rsp_err=1, rsp_id=1.
- Timeout: ALU model never raises alu_out_valid, TIMEOUT=4 -> rsp_err=1, rsp_data=0, rsp_valid at T+6.
- Backpressure: rsp_ready held 0 for 10 cycles after rsp_valid -> response fields stable; both readies 0 throughout; next grant the cycle after the handshake.
- Reset mid-WAIT: RST low for 1 cycle during WAIT -> all outputs 0 immediately; no response emitted; next request gets normal 3-cycle latency.
